// File: rtl/img_stream_pkg.sv
// Shared types and constants for the RGB565 pixel-stream generator.
package img_stream_pkg;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    FRAME = 2'd2
  } state_t;

  localparam rgb565_t UNDERFLOW_PIXEL = 16'h0000;

  // White, yellow, cyan, green, magenta, red, blue, black
  localparam rgb565_t COLOR_BARS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  function automatic rgb565_t bar_color(input logic [2:0] idx);
    return COLOR_BARS[idx];
  endfunction

endpackage

// File: rtl/img_timing_cnt.sv
// Horizontal/vertical position counters with the region flags the
// transmitter FSM needs (active window, vs region, sync/frame end).
module img_timing_cnt #(
  parameter logic [9:0] IMG_H   = 10'd800,
  parameter logic [9:0] IMG_V   = 10'd600,
  parameter logic [9:0] H_BLANK = 10'd160,
  parameter logic [9:0] V_SYNC  = 10'd4,
  parameter logic [9:0] V_PRE   = 10'd8,
  parameter logic [9:0] V_POST  = 10'd8,
  parameter int HW = $clog2(int'(IMG_H) + int'(H_BLANK)),
  parameter int VW = $clog2(int'(V_SYNC) + int'(V_PRE) + int'(IMG_V) + int'(V_POST))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          vs_region,
  output logic          sync_last,
  output logic          frame_last
);

  localparam int LINE        = int'(IMG_H) + int'(H_BLANK);
  localparam int FRAME_LINES = int'(V_SYNC) + int'(V_PRE) + int'(IMG_V) + int'(V_POST);
  localparam int ACT_V0      = int'(V_SYNC) + int'(V_PRE);
  localparam int ACT_V1      = ACT_V0 + int'(IMG_V);

  logic line_last;

  assign line_last  = (int'(h_cnt) == LINE - 1);
  assign frame_last = line_last && (int'(v_cnt) == FRAME_LINES - 1);
  assign sync_last  = line_last && (int'(v_cnt) == int'(V_SYNC) - 1);
  assign vs_region  = (int'(v_cnt) >= int'(V_SYNC));
  assign active     = (int'(v_cnt) >= ACT_V0) && (int'(v_cnt) < ACT_V1) &&
                      (int'(h_cnt) < int'(IMG_H));

  // Counters sit at the frame origin while idle so a new frame starts cleanly.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_last) begin
      h_cnt <= '0;
      v_cnt <= frame_last ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

endmodule

// File: rtl/img_stream_gen.sv
// vs/hs/clken + RGB565 stream transmitter with rigid frame timing.
// Optional colour-bar generator enabled by defining TEST_PATTERN_EN.
module img_stream_gen
  import img_stream_pkg::*;
#(
  parameter logic [9:0] IMG_H   = 10'd800,
  parameter logic [9:0] IMG_V   = 10'd600,
  parameter logic [9:0] H_BLANK = 10'd160,
  parameter logic [9:0] V_SYNC  = 10'd4,
  parameter logic [9:0] V_PRE   = 10'd8,
  parameter logic [9:0] V_POST  = 10'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        test_mode,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        post_vs,
  output logic        post_hs,
  output logic        post_clken,
  output logic [15:0] post_img_data,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] underflow_cnt
);

  localparam int HW = $clog2(int'(IMG_H) + int'(H_BLANK));
  localparam int VW = $clog2(int'(V_SYNC) + int'(V_PRE) + int'(IMG_V) + int'(V_POST));

  state_t        state_reg;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          running;
  logic          active;
  logic          vs_region;
  logic          sync_last;
  logic          frame_last;
  logic          pix_active;
  logic          starve;
  rgb565_t       pix_data;

  assign running = (state_reg != IDLE);

  img_timing_cnt #(
    .IMG_H  (IMG_H),
    .IMG_V  (IMG_V),
    .H_BLANK(H_BLANK),
    .V_SYNC (V_SYNC),
    .V_PRE  (V_PRE),
    .V_POST (V_POST),
    .HW     (HW),
    .VW     (VW)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .run       (running),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (active),
    .vs_region (vs_region),
    .sync_last (sync_last),
    .frame_last(frame_last)
  );

  assign pix_active = (state_reg == FRAME) && active;
  assign starve     = in_ready && !in_valid;

`ifdef TEST_PATTERN_EN
  logic [2:0] bar_idx;

  assign bar_idx  = 3'((int'(h_cnt) * 8) / int'(IMG_H));
  assign in_ready = pix_active && !test_mode;

  always_comb begin
    pix_data = UNDERFLOW_PIXEL;
    if (pix_active) begin
      if (test_mode)     pix_data = bar_color(bar_idx);
      else if (in_valid) pix_data = in_data;
    end
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{test_mode, h_cnt};
  assign in_ready      = pix_active;

  always_comb begin
    pix_data = UNDERFLOW_PIXEL;
    if (pix_active && in_valid) pix_data = in_data;
  end
`endif

  // A starved slot is still emitted (data 0) so line timing never slips.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      post_vs       <= 1'b0;
      post_hs       <= 1'b0;
      post_clken    <= 1'b0;
      post_img_data <= '0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      unique case (state_reg)
        IDLE:    if (enable) state_reg <= SYNC;
        SYNC:    if (sync_last) state_reg <= FRAME;
        FRAME:   if (frame_last) state_reg <= enable ? SYNC : IDLE;
        default: state_reg <= IDLE;
      endcase
      post_clken    <= pix_active;
      post_hs       <= pix_active;
      post_vs       <= (state_reg == FRAME) && vs_region;
      post_img_data <= pix_data;
      frame_done    <= (state_reg == FRAME) && frame_last;
      busy          <= running;
      if (starve && (underflow_cnt != 16'hFFFF))
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule
